mvm_uart_sequencer: RTL and testbench

- Frame controller between the UART byte receiver/transmitter and the R x C matrix-vector multiply datapath inside the MVM UART system.
- Collects a frame of K-matrix and X-vector elements from the RX byte stream, issues one start pulse to the MVM core and waits for completion.
- Streams the R result words back out through the TX byte interface, then rearms for the next frame.

---
 rtl/mvm_uart_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mvm_uart_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_uart_sequencer.sv
// rtl/mvm_uart_sequencer.sv - UART frame sequencer for the R x C matrix-vector multiply core.
// Optional frame checksum byte and chk_err port: define MVM_SEQ_CHECKSUM_EN.
module mvm_uart_sequencer #(
    parameter int R             = 2,
    parameter int C             = 2,
    parameter int W_K           = 4,
    parameter int W_X           = 4,
    parameter int W_Y_OUT       = 8,
    parameter int BITS_PER_WORD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid,
    input  logic [BITS_PER_WORD-1:0]   rx_data,
    output logic [R*C*W_K-1:0]         k_flat,
    output logic [C*W_X-1:0]           x_flat,
    output logic                       mvm_start,
    input  logic                       mvm_done,
    input  logic [R*W_Y_OUT-1:0]       y_in,
    output logic [BITS_PER_WORD-1:0]   tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       overrun
`ifdef MVM_SEQ_CHECKSUM_EN
    ,
    output logic                       chk_err
`endif
);

    localparam int KN      = R * C;
    localparam int IDX_MAX = (KN > R) ? KN : R;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(KN - 1);
    localparam logic [IDX_W-1:0] X_LAST = IDX_W'(C - 1);
    localparam logic [IDX_W-1:0] Y_LAST = IDX_W'(R - 1);

    typedef enum logic [2:0] {
        S_LOAD_K,
        S_LOAD_X,
        S_CHECK,
        S_START,
        S_WAIT,
        S_SEND
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [R*W_Y_OUT-1:0]   y_reg;
`ifdef MVM_SEQ_CHECKSUM_EN
    logic [BITS_PER_WORD-1:0] csum;
`endif

    // Only the low element bits of each byte are meaningful.
    logic unused_rx_bits;
    assign unused_rx_bits = ^rx_data;

    function automatic logic [BITS_PER_WORD-1:0] sext_y(input logic [W_Y_OUT-1:0] v);
        return BITS_PER_WORD'($signed(v));
    endfunction

    assign busy = !(state == S_LOAD_K && idx == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_LOAD_K;
            idx       <= '0;
            k_flat    <= '0;
            x_flat    <= '0;
            y_reg     <= '0;
            mvm_start <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            overrun   <= 1'b0;
`ifdef MVM_SEQ_CHECKSUM_EN
            csum      <= '0;
            chk_err   <= 1'b0;
`endif
        end else begin
            mvm_start <= 1'b0;
`ifdef MVM_SEQ_CHECKSUM_EN
            chk_err   <= 1'b0;
`endif
            case (state)
                S_LOAD_K: begin
                    if (rx_valid) begin
                        k_flat[int'(idx)*W_K +: W_K] <= rx_data[W_K-1:0];
`ifdef MVM_SEQ_CHECKSUM_EN
                        csum <= (idx == '0) ? rx_data : (csum ^ rx_data);
`endif
                        if (idx == K_LAST) begin
                            idx   <= '0;
                            state <= S_LOAD_X;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_LOAD_X: begin
                    if (rx_valid) begin
                        x_flat[int'(idx)*W_X +: W_X] <= rx_data[W_X-1:0];
`ifdef MVM_SEQ_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (idx == X_LAST) begin
                            idx <= '0;
`ifdef MVM_SEQ_CHECKSUM_EN
                            state <= S_CHECK;
`else
                            state     <= S_START;
                            mvm_start <= 1'b1;
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
`ifdef MVM_SEQ_CHECKSUM_EN
                S_CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == csum) begin
                            state     <= S_START;
                            mvm_start <= 1'b1;
                        end else begin
                            chk_err <= 1'b1;
                            state   <= S_LOAD_K;
                        end
                    end
                end
`endif
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mvm_done) begin
                        y_reg    <= y_in;
                        idx      <= '0;
                        tx_data  <= sext_y(y_in[0 +: W_Y_OUT]);
                        tx_valid <= 1'b1;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (idx == Y_LAST) begin
                            tx_valid <= 1'b0;
                            idx      <= '0;
                            state    <= S_LOAD_K;
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            tx_data <= sext_y(y_reg[(int'(idx) + 1)*W_Y_OUT +: W_Y_OUT]);
                        end
                    end
                end
                default: begin
                    state <= S_LOAD_K;
                    idx   <= '0;
                end
            endcase

            // Bytes arriving while the frame is being processed or drained are lost.
            if (rx_valid && (state == S_START || state == S_WAIT || state == S_SEND))
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mvm_uart_sequencer.sv
// tb/tb_mvm_uart_sequencer.sv - randomized self-checking bench for mvm_uart_sequencer.
module tb_mvm_uart_sequencer;

    localparam int R  = 2;
    localparam int C  = 2;
    localparam int N  = R*C + C;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [R*C*4-1:0]  k_flat;
    logic [C*4-1:0]    x_flat;
    logic              mvm_start;
    logic              mvm_done;
    logic [R*8-1:0]    y_in;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              overrun;
`ifdef MVM_SEQ_CHECKSUM_EN
    logic              chk_err;
`endif

    mvm_uart_sequencer #(
        .R(R), .C(C), .W_K(4), .W_X(4), .W_Y_OUT(8), .BITS_PER_WORD(8)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .k_flat(k_flat), .x_flat(x_flat), .mvm_start(mvm_start),
        .mvm_done(mvm_done), .y_in(y_in), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .overrun(overrun)
`ifdef MVM_SEQ_CHECKSUM_EN
        , .chk_err(chk_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] fb [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int s4(input logic [3:0] v);
        logic signed [3:0] t;
        t = v;
        return int'(t);
    endfunction

    // Expected values come straight from the bytes the bench sent.
    function automatic logic [7:0] exp_y(input int r);
        int acc = 0;
        for (int c = 0; c < C; c++) acc += s4(fb[r*C+c][3:0]) * s4(fb[R*C+c][3:0]);
        return acc[7:0];
    endfunction

    function automatic logic [R*C*4-1:0] exp_k();
        logic [R*C*4-1:0] v = '0;
        for (int i = 0; i < R*C; i++) v[i*4 +: 4] = fb[i][3:0];
        return v;
    endfunction

    function automatic logic [C*4-1:0] exp_x();
        logic [C*4-1:0] v = '0;
        for (int i = 0; i < C; i++) v[i*4 +: 4] = fb[R*C+i][3:0];
        return v;
    endfunction

    function automatic logic [7:0] frame_xor();
        logic [7:0] v = '0;
        for (int i = 0; i < N; i++) v ^= fb[i];
        return v;
    endfunction

    // Stand-in for the MVM core: works from whatever the sequencer presents.
    function automatic logic [R*8-1:0] core_y(input logic [R*C*4-1:0] k, input logic [C*4-1:0] x);
        logic [R*8-1:0] y = '0;
        for (int r = 0; r < R; r++) begin
            int acc = 0;
            for (int c = 0; c < C; c++) acc += s4(k[(r*C+c)*4 +: 4]) * s4(x[c*4 +: 4]);
            y[r*8 +: 8] = acc[7:0];
        end
        return y;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = $urandom_range(0, 255);
    endtask

    task automatic do_frame(input int lat, input int bp, input bit ovr, input bit rst_send, input bit bad_csum);
        int got, cyc, hold;
        bit prev_stall;
        logic [7:0] prev;
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(fb[i]);
            if (i == 0) check("busy_after_first", busy, 1);
            if (i < N-1) check("no_early_start", mvm_start, 0);
        end
`ifdef MVM_SEQ_CHECKSUM_EN
        check("no_start_in_check", mvm_start, 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(bad_csum ? (frame_xor() ^ 8'hFF) : frame_xor());
        if (bad_csum) begin
            check("chk_err_pulse", chk_err, 1);
            check("chk_no_start", mvm_start, 0);
            check("chk_k_kept", k_flat, exp_k());
            @(negedge clk);
            check("chk_err_clear", chk_err, 0);
            check("chk_idle", busy, 0);
            return;
        end
        check("chk_err_quiet", chk_err, 0);
`endif
        check("start_pulse", mvm_start, 1);
        check("k_flat", k_flat, exp_k());
        check("x_flat", x_flat, exp_x());
        @(negedge clk);
        check("start_one_cycle", mvm_start, 0);
        if (ovr) begin
            send_byte(8'hAA);
            check("overrun_set", overrun, 1);
            check("k_after_ovr", k_flat, exp_k());
            check("x_after_ovr", x_flat, exp_x());
        end
        repeat (lat) @(negedge clk);
        mvm_done = 1'b1;
        y_in     = core_y(k_flat, x_flat);
        @(negedge clk);
        mvm_done = 1'b0;
        y_in     = {$urandom, $urandom};
        check("tx_valid_first", tx_valid, 1);
        if (rst_send) begin
            tx_ready = 1'b0;
            rst = 1'b1;
            #1;
            check("rst_tx_valid_async", tx_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_tx_data", tx_data, 0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            return;
        end
        got = 0; cyc = 0; hold = bp; prev_stall = 0; prev = '0;
        while (got < R && cyc < 200) begin
            check("tx_valid_send", tx_valid, 1);
            if (prev_stall) check("tx_stable", tx_data, prev);
            tx_ready = (hold > 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (hold > 0) hold--;
            if (tx_ready && tx_valid) begin
                check($sformatf("tx_byte%0d", got), tx_data, exp_y(got));
                got++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev = tx_data;
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b0;
        check("tx_count", got, R);
        check("tx_valid_drop", tx_valid, 0);
        check("back_to_idle", busy, 0);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < N; i++) fb[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; mvm_done = 1'b0;
        y_in = '0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_k", k_flat, 0);
        check("rst_x", x_flat, 0);
        check("rst_start", mvm_start, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        check("model_basic_y0", exp_y(0), 8'h11);
        do_frame(5, 0, 0, 0, 0);

        fb = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'h02, 8'h01};
        do_frame(3, 0, 0, 0, 0);
        check("neg_k00", k_flat[3:0], 4'hF);

        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        do_frame(2, 10, 0, 0, 0);
        check("no_overrun_yet", overrun, 0);

        rand_frame();
        do_frame(4, 0, 1, 0, 0);
        rand_frame();
        do_frame(1, 0, 0, 0, 0);
        check("overrun_sticky", overrun, 1);

        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
        rst = 1'b1;
        #1;
        check("midload_rst_k", k_flat, 0);
        check("midload_rst_x", x_flat, 0);
        check("midload_rst_busy", busy, 0);
        check("midload_rst_ovr", overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rand_frame();
        do_frame(3, 0, 0, 0, 0);

        rand_frame();
        do_frame(2, 0, 0, 1, 0);
        rand_frame();
        do_frame(2, 0, 0, 0, 0);

        for (int t = 0; t < 8; t++) begin
            rand_frame();
            do_frame($urandom_range(0, 6), $urandom_range(0, 4), 0, 0, 0);
        end

`ifdef MVM_SEQ_CHECKSUM_EN
        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        check("model_csum", frame_xor(), 8'h07);
        do_frame(2, 0, 0, 0, 0);
        do_frame(2, 0, 0, 0, 1);
        rand_frame();
        do_frame(2, 0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
